// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, response codes, default-slave states, address map.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Default-slave FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } def_state_t;

    localparam int NUM_SLAVES = 4;

    // Default address map
    localparam logic [31:0] S0_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] S0_MASK_DEF = 32'hFFFF_0000;
    localparam logic [31:0] S1_BASE_DEF = 32'h2000_0000;
    localparam logic [31:0] S1_MASK_DEF = 32'hFFFF_0000;
    localparam logic [31:0] S2_BASE_DEF = 32'h4000_0000;
    localparam logic [31:0] S2_MASK_DEF = 32'hFFFF_F000;
    localparam logic [31:0] S3_BASE_DEF = 32'h4000_1000;
    localparam logic [31:0] S3_MASK_DEF = 32'hFFFF_F000;

    // Region hit: masked address equals the region base.
    function automatic logic region_hit(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return (addr & mask) == base;
    endfunction

    // Active transfer (NONSEQ or SEQ) -- IDLE and BUSY never need a response.
    function automatic logic trans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR (ERR1 wait, ERR2 ready).
// Latency: ERROR starts the cycle after the sampling edge; ERR2 can chain straight into a new ERR1.
// Backpressure: only samples sel_default when HREADY=1; drives HREADYOUT=0 during ERR1.
//
// Ports:
//   HCLK, HRESETn  clock, async active-low reset
//   HREADY         bus ready (qualifies address-phase sampling)
//   sel_default    address phase is an unmapped NONSEQ/SEQ
//   HREADYOUT      default slave ready
//   HRESP          default slave response
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic HREADY,
    input  logic sel_default,
    output logic HREADYOUT,
    output logic HRESP
);

    def_state_t r_state;
    def_state_t w_state_nxt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        HREADYOUT   = 1'b1;
        HRESP       = HRESP_OKAY;
        case (r_state)
            IDLE: begin
                if (HREADY && sel_default) begin
                    w_state_nxt = ERR1;
                end
            end
            ERR1: begin
                // First ERROR cycle holds the bus so the master can cancel its next transfer.
                HREADYOUT   = 1'b0;
                HRESP       = HRESP_ERROR;
                w_state_nxt = ERR2;
            end
            ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_ERROR;
                // The edge ending ERR2 also samples the next address phase.
                if (HREADY && sel_default) begin
                    w_state_nxt = ERR1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_decoder.sv
// AHB-Lite address decoder and data-phase response mux with a built-in default slave.
// Latency: HSEL is combinational; HSEL_D/DEF_SEL register on the HREADY=1 edge; response mux is combinational.
// Backpressure: HSEL_D/DEF_SEL hold while HREADY=0; HREADY follows the data-phase owner's HREADYOUT.
//
// Ports:
//   HCLK, HRESETn              clock, async active-low reset
//   HADDR, HTRANS              master address phase
//   HREADYOUT0..3, HRESP0..3   slave responses
//   HSEL                       address-phase one-hot select
//   HSEL_D                     data-phase one-hot select
//   HREADY, HRESP              muxed response to master / slaves
//   DEF_SEL                    default slave owns the data phase
module ahb_decoder
    import ahb_pkg::*;
#(
    parameter logic [31:0] S0_BASE = S0_BASE_DEF,
    parameter logic [31:0] S0_MASK = S0_MASK_DEF,
    parameter logic [31:0] S1_BASE = S1_BASE_DEF,
    parameter logic [31:0] S1_MASK = S1_MASK_DEF,
    parameter logic [31:0] S2_BASE = S2_BASE_DEF,
    parameter logic [31:0] S2_MASK = S2_MASK_DEF,
    parameter logic [31:0] S3_BASE = S3_BASE_DEF,
    parameter logic [31:0] S3_MASK = S3_MASK_DEF
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADYOUT0,
    input  logic        HREADYOUT1,
    input  logic        HREADYOUT2,
    input  logic        HREADYOUT3,
    input  logic        HRESP0,
    input  logic        HRESP1,
    input  logic        HRESP2,
    input  logic        HRESP3,
    output logic [3:0]  HSEL,
    output logic [3:0]  HSEL_D,
    output logic        HREADY,
    output logic        HRESP,
    output logic        DEF_SEL
);

    logic [NUM_SLAVES-1:0] w_hit;
    logic [NUM_SLAVES-1:0] w_hsel;
    logic                  w_unmapped;
    logic                  w_sel_default;
    logic [NUM_SLAVES-1:0] w_slv_ready;
    logic [NUM_SLAVES-1:0] w_slv_resp;
    logic                  w_def_hreadyout;
    logic                  w_def_hresp;
    logic                  w_hready;
    logic                  w_hresp;
    logic [NUM_SLAVES-1:0] r_hsel_d;
    logic                  r_def_sel;

    // ------------------------------------------------------------------
    // Address decode (independent of HTRANS)
    // ------------------------------------------------------------------
    assign w_hit[0] = region_hit(HADDR, S0_BASE, S0_MASK);
    assign w_hit[1] = region_hit(HADDR, S1_BASE, S1_MASK);
    assign w_hit[2] = region_hit(HADDR, S2_BASE, S2_MASK);
    assign w_hit[3] = region_hit(HADDR, S3_BASE, S3_MASK);

    // Overlapping regions resolve to the lowest index so HSEL stays one-hot.
    always_comb begin
        w_hsel = '0;
        if (w_hit[0]) begin
            w_hsel = 4'b0001;
        end else if (w_hit[1]) begin
            w_hsel = 4'b0010;
        end else if (w_hit[2]) begin
            w_hsel = 4'b0100;
        end else if (w_hit[3]) begin
            w_hsel = 4'b1000;
        end
    end

    assign w_unmapped    = ~|w_hit;
    // Only active transfers to unmapped space need an ERROR; IDLE/BUSY get zero-wait OKAY.
    assign w_sel_default = w_unmapped & trans_active(HTRANS);

    assign HSEL = w_hsel;

    // ------------------------------------------------------------------
    // Data-phase select register
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hsel_d  <= '0;
            r_def_sel <= 1'b0;
        end else if (w_hready) begin
            r_hsel_d  <= w_hsel;
            r_def_sel <= w_sel_default;
        end
    end

    assign HSEL_D  = r_hsel_d;
    assign DEF_SEL = r_def_sel;

    // ------------------------------------------------------------------
    // Default slave
    // ------------------------------------------------------------------
    ahb_default_slave u_default_slave (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HREADY      (w_hready),
        .sel_default (w_sel_default),
        .HREADYOUT   (w_def_hreadyout),
        .HRESP       (w_def_hresp)
    );

    // ------------------------------------------------------------------
    // Response mux
    // ------------------------------------------------------------------
    assign w_slv_ready = {HREADYOUT3, HREADYOUT2, HREADYOUT1, HREADYOUT0};
    assign w_slv_resp  = {HRESP3, HRESP2, HRESP1, HRESP0};

    // DEF_SEL tracks the FSM being in ERR1/ERR2 exactly, and is exclusive with HSEL_D,
    // so it can take priority. No owner means a zero-wait OKAY.
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        if (r_def_sel) begin
            w_hready = w_def_hreadyout;
            w_hresp  = w_def_hresp;
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (r_hsel_d[i]) begin
                    w_hready = w_slv_ready[i];
                    w_hresp  = w_slv_resp[i];
                end
            end
        end
    end

    assign HREADY = w_hready;
    assign HRESP  = w_hresp;

endmodule

// File: tb/tb_ahb_decoder.sv
// Self-checking bench for ahb_decoder: decode table plus directed multi-cycle sequences.
module tb_ahb_decoder;
    import ahb_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADYOUT0, HREADYOUT1, HREADYOUT2, HREADYOUT3;
    logic        HRESP0, HRESP1, HRESP2, HRESP3;
    logic [3:0]  HSEL;
    logic [3:0]  HSEL_D;
    logic        HREADY;
    logic        HRESP;
    logic        DEF_SEL;

    int n_checks = 0;
    int n_errors = 0;

    ahb_decoder dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HREADYOUT0 (HREADYOUT0),
        .HREADYOUT1 (HREADYOUT1),
        .HREADYOUT2 (HREADYOUT2),
        .HREADYOUT3 (HREADYOUT3),
        .HRESP0     (HRESP0),
        .HRESP1     (HRESP1),
        .HRESP2     (HRESP2),
        .HRESP3     (HRESP3),
        .HSEL       (HSEL),
        .HSEL_D     (HSEL_D),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .DEF_SEL    (DEF_SEL)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [3:0]  hsel;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [1:0] trans);
        HADDR  = addr;
        HTRANS = trans;
    endtask

    // HSEL_D and DEF_SEL must never both claim the data phase.
    always @(negedge HCLK) begin
        n_checks++;
        if ((HSEL_D != 4'b0000) && DEF_SEL) begin
            n_errors++;
            $display("FAIL invariant: HSEL_D=%b DEF_SEL=%b at %0t", HSEL_D, DEF_SEL, $time);
        end
    end

    initial begin
        vecs[0]  = '{32'h0000_0010, HTRANS_IDLE, 4'b0001};
        vecs[1]  = '{32'h0000_FFFC, HTRANS_BUSY, 4'b0001};
        vecs[2]  = '{32'h0001_0000, HTRANS_IDLE, 4'b0000};
        vecs[3]  = '{32'h2000_0004, HTRANS_BUSY, 4'b0010};
        vecs[4]  = '{32'h2000_FFFF, HTRANS_IDLE, 4'b0010};
        vecs[5]  = '{32'h2001_0000, HTRANS_BUSY, 4'b0000};
        vecs[6]  = '{32'h4000_0000, HTRANS_IDLE, 4'b0100};
        vecs[7]  = '{32'h4000_0FFC, HTRANS_BUSY, 4'b0100};
        vecs[8]  = '{32'h4000_1008, HTRANS_IDLE, 4'b1000};
        vecs[9]  = '{32'h4000_1FFF, HTRANS_BUSY, 4'b1000};
        vecs[10] = '{32'h4000_2000, HTRANS_IDLE, 4'b0000};
        vecs[11] = '{32'h8000_0000, HTRANS_BUSY, 4'b0000};
        vecs[12] = '{32'hFFFF_FFFF, HTRANS_IDLE, 4'b0000};

        HRESETn    = 1'b0;
        HADDR      = 32'h0000_0010;
        HTRANS     = HTRANS_IDLE;
        HREADYOUT0 = 1'b1; HREADYOUT1 = 1'b1; HREADYOUT2 = 1'b1; HREADYOUT3 = 1'b1;
        HRESP0     = 1'b0; HRESP1     = 1'b0; HRESP2     = 1'b0; HRESP3     = 1'b0;

        // Reset state
        #3;
        chk("rst_hsel",    HSEL,    4'b0001);
        chk("rst_hsel_d",  HSEL_D,  4'b0000);
        chk("rst_def_sel", DEF_SEL, 1'b0);
        chk("rst_hready",  HREADY,  1'b1);
        chk("rst_hresp",   HRESP,   1'b0);
        cyc();
        cyc();
        HRESETn = 1'b1;

        // Decode table: IDLE/BUSY only, so every data phase is a zero-wait OKAY.
        for (int i = 0; i < 13; i++) begin
            cyc();
            drive(vecs[i].addr, vecs[i].trans);
            #2;
            chk($sformatf("tbl_hsel[%0d]", i), HSEL, vecs[i].hsel);
            if (i > 0) begin
                chk($sformatf("tbl_hsel_d[%0d]", i - 1), HSEL_D, vecs[i - 1].hsel);
                chk($sformatf("tbl_def_sel[%0d]", i - 1), DEF_SEL, 1'b0);
                chk($sformatf("tbl_hready[%0d]", i - 1), HREADY, 1'b1);
            end
        end

        // Zero-wait transfer to slave 1
        cyc();
        drive(32'h2000_0004, HTRANS_NONSEQ);
        #2;
        chk("tbl_hsel_d_last", HSEL_D, vecs[12].hsel);
        chk("zw_hsel", HSEL, 4'b0010);
        cyc();
        drive(32'h0000_0000, HTRANS_IDLE);
        #2;
        chk("zw_hsel_d", HSEL_D, 4'b0010);
        chk("zw_hready", HREADY, 1'b1);
        chk("zw_hresp",  HRESP,  1'b0);
        HRESP1 = 1'b1;
        #1;
        chk("zw_hresp_route", HRESP, 1'b1);
        HRESP1 = 1'b0;

        // Wait states on slave 3: three cycles of HREADYOUT3=0
        cyc();
        drive(32'h4000_1008, HTRANS_NONSEQ);
        #2;
        chk("ws_hsel", HSEL, 4'b1000);
        cyc();
        HREADYOUT3 = 1'b0;
        drive(32'h0000_0000, HTRANS_NONSEQ);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("ws_hready_low[%0d]", k), HREADY, 1'b0);
            chk($sformatf("ws_hsel_d_hold[%0d]", k), HSEL_D, 4'b1000);
            cyc();
        end
        HREADYOUT3 = 1'b1;
        #2;
        chk("ws_hready_back", HREADY, 1'b1);
        chk("ws_hsel_d_last", HSEL_D, 4'b1000);
        cyc();
        drive(32'h8000_0000, HTRANS_IDLE);
        #2;
        chk("ws_next_sampled", HSEL_D, 4'b0001);
        chk("ws_next_hready", HREADY, 1'b1);

        // Unmapped IDLE: no error
        cyc();
        #2;
        chk("ui_hsel_d",  HSEL_D,  4'b0000);
        chk("ui_def_sel", DEF_SEL, 1'b0);
        chk("ui_hready",  HREADY,  1'b1);
        chk("ui_hresp",   HRESP,   1'b0);

        // Unmapped NONSEQ: ERR1, ERR2, then OKAY
        cyc();
        drive(32'h8000_0000, HTRANS_NONSEQ);
        #2;
        chk("ue_addr_hsel", HSEL, 4'b0000);
        chk("ue_addr_hresp", HRESP, 1'b0);
        cyc();
        drive(32'h8000_0000, HTRANS_IDLE);
        #2;
        chk("ue_err1_def_sel", DEF_SEL, 1'b1);
        chk("ue_err1_hsel_d",  HSEL_D,  4'b0000);
        chk("ue_err1_hready",  HREADY,  1'b0);
        chk("ue_err1_hresp",   HRESP,   1'b1);
        cyc();
        #2;
        chk("ue_err2_def_sel", DEF_SEL, 1'b1);
        chk("ue_err2_hready",  HREADY,  1'b1);
        chk("ue_err2_hresp",   HRESP,   1'b1);
        cyc();
        #2;
        chk("ue_ok_def_sel", DEF_SEL, 1'b0);
        chk("ue_ok_hready",  HREADY,  1'b1);
        chk("ue_ok_hresp",   HRESP,   1'b0);

        // Unmapped SEQ, then NONSEQ to slave 2 presented during the error
        cyc();
        drive(32'h8000_0000, HTRANS_SEQ);
        cyc();
        drive(32'h4000_0000, HTRANS_NONSEQ);
        #2;
        chk("pe_err1_hready", HREADY, 1'b0);
        chk("pe_err1_hresp",  HRESP,  1'b1);
        cyc();
        HREADYOUT2 = 1'b0;
        #2;
        chk("pe_err2_hready", HREADY, 1'b1);
        chk("pe_err2_hresp",  HRESP,  1'b1);
        cyc();
        drive(32'h0000_0000, HTRANS_IDLE);
        #2;
        chk("pe_hsel_d",   HSEL_D,  4'b0100);
        chk("pe_def_sel",  DEF_SEL, 1'b0);
        chk("pe_s2_ready", HREADY,  1'b0);
        chk("pe_s2_resp",  HRESP,   1'b0);
        cyc();
        HREADYOUT2 = 1'b1;
        #2;
        chk("pe_hsel_d_hold", HSEL_D, 4'b0100);
        chk("pe_s2_ready_hi", HREADY, 1'b1);

        // Back-to-back unmapped transfers: ERR2 chains straight into ERR1
        cyc();
        drive(32'h8000_0000, HTRANS_NONSEQ);
        cyc();
        #2;
        chk("bb_err1a_hready", HREADY, 1'b0);
        cyc();
        #2;
        chk("bb_err2a_hready", HREADY, 1'b1);
        chk("bb_err2a_hresp",  HRESP,  1'b1);
        cyc();
        drive(32'h8000_0000, HTRANS_IDLE);
        #2;
        chk("bb_err1b_hready",  HREADY,  1'b0);
        chk("bb_err1b_hresp",   HRESP,   1'b1);
        chk("bb_err1b_def_sel", DEF_SEL, 1'b1);
        cyc();
        #2;
        chk("bb_err2b_hready", HREADY, 1'b1);
        chk("bb_err2b_hresp",  HRESP,  1'b1);
        cyc();
        #2;
        chk("bb_ok_hresp",   HRESP,   1'b0);
        chk("bb_ok_def_sel", DEF_SEL, 1'b0);

        // Reset in the middle of an error response
        cyc();
        drive(32'h8000_0000, HTRANS_NONSEQ);
        cyc();
        #2;
        chk("mr_err1_hready", HREADY, 1'b0);
        HRESETn = 1'b0;
        #1;
        chk("mr_hsel_d",  HSEL_D,  4'b0000);
        chk("mr_def_sel", DEF_SEL, 1'b0);
        chk("mr_hready",  HREADY,  1'b1);
        chk("mr_hresp",   HRESP,   1'b0);
        cyc();
        drive(32'h0000_0010, HTRANS_NONSEQ);
        #2;
        chk("mr_hsel_in_rst",   HSEL,   4'b0001);
        chk("mr_hsel_d_in_rst", HSEL_D, 4'b0000);
        HRESETn = 1'b1;
        cyc();
        drive(32'h0000_0000, HTRANS_IDLE);
        #2;
        chk("mr_after_hsel_d", HSEL_D, 4'b0001);
        chk("mr_after_hready", HREADY, 1'b1);
        chk("mr_after_hresp",  HRESP,  1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
